// File: rtl/qa_drv_hc_rx_line_splitter.sv
// ---------------------------------------------------------------------------
// qa_drv_hc_rx_line_splitter
//
// Purpose:
//   Takes 512-bit cache lines from the host-to-FPGA ring-buffer reader and
//   hands their payload to the channel client as narrow chunks.
//   - Chunk 0 of every line is a header. Its low N_CNT_BITS bits give the
//     number of payload chunks that follow.
//   - Only payload chunks 1..cnt are emitted.
//   - A line with cnt == 0 is dequeued and dropped.
//   - A count larger than N_CHUNKS-1 is clamped to N_CHUNKS-1. It also
//     sets the sticky hdr_err flag.
//   - The next line is loaded in the same cycle that the last chunk of the
//     current line is consumed, so there is no gap between lines.
//
// Optional build macro:
//   QA_DRV_HC_RX_SPLIT_STATS_EN
//     Defined:   stat_lines / stat_chunks are live 32-bit wrapping counters.
//     Undefined: both outputs are tied to zero.
//
// Ports:
//   clk         in   single clock
//   reset_n     in   asynchronous active-low reset
//   line_data   in   head line from the upstream reader (first-word-fall-through)
//   line_rdy    in   line_data is valid
//   line_deq    out  pops the upstream line this cycle (combinational)
//   chunk_data  out  current payload chunk (muxed from the line register)
//   chunk_rdy   out  chunk_data is valid
//   chunk_deq   in   client consumes chunk_data this cycle
//   hdr_err     out  sticky: a header count exceeded N_CHUNKS-1
//   stat_lines  out  lines dequeued (optional counter)
//   stat_chunks out  chunks consumed (optional counter)
// ---------------------------------------------------------------------------
module qa_drv_hc_rx_line_splitter #(
  parameter int N_CHUNK_BITS = 64,
  parameter int N_CNT_BITS   = 4,
  localparam int CCI_CLDATA_WIDTH = 512
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic [CCI_CLDATA_WIDTH-1:0] line_data,
  input  logic                        line_rdy,
  output logic                        line_deq,
  output logic [N_CHUNK_BITS-1:0]     chunk_data,
  output logic                        chunk_rdy,
  input  logic                        chunk_deq,
  output logic                        hdr_err,
  output logic [31:0]                 stat_lines,
  output logic [31:0]                 stat_chunks
);

  localparam int N_CHUNKS = CCI_CLDATA_WIDTH / N_CHUNK_BITS;
  localparam int IDX_W    = (N_CHUNKS > 1) ? $clog2(N_CHUNKS) : 1;

  localparam logic [N_CNT_BITS-1:0] MAX_CNT  = N_CNT_BITS'(N_CHUNKS - 1);
  localparam logic [IDX_W-1:0]      MAX_IDX  = IDX_W'(N_CHUNKS - 1);
  localparam logic [IDX_W-1:0]      IDX_ONE  = IDX_W'(1);
  localparam logic [IDX_W-1:0]      IDX_ZERO = '0;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_EMIT = 1'b1
  } state_e;

  state_e                      state_q, state_d;
  logic [CCI_CLDATA_WIDTH-1:0] line_buf_q, line_buf_d;
  logic [IDX_W-1:0]            idx_q, idx_d;
  logic [IDX_W-1:0]            last_q, last_d;
  logic                        hdr_err_q, hdr_err_d;
  logic                        load;

  // -------------------------------------------------------------------------
  // Header decode on the incoming line. Only the low N_CNT_BITS bits of
  // chunk 0 are significant; the remaining header bits are ignored.
  // -------------------------------------------------------------------------
  logic [N_CNT_BITS-1:0] hdr_cnt;
  logic                  cnt_over;
  logic [IDX_W-1:0]      eff_cnt;

  assign hdr_cnt  = line_data[N_CNT_BITS-1:0];
  assign cnt_over = (hdr_cnt > MAX_CNT);
  assign eff_cnt  = cnt_over ? MAX_IDX : hdr_cnt[IDX_W-1:0];

  // -------------------------------------------------------------------------
  // Split the registered line into addressable chunks.
  // The output mux reads only from the line register, so line_data has no
  // combinational path to chunk_data.
  // -------------------------------------------------------------------------
  logic [N_CHUNK_BITS-1:0] buf_chunk [N_CHUNKS];

  for (genvar gi = 0; gi < N_CHUNKS; gi++) begin : g_chunk
    assign buf_chunk[gi] = line_buf_q[gi*N_CHUNK_BITS +: N_CHUNK_BITS];
  end

  assign chunk_data = buf_chunk[idx_q];
  assign chunk_rdy  = (state_q == S_EMIT);
  assign line_deq   = load;
  assign hdr_err    = hdr_err_q;

  // -------------------------------------------------------------------------
  // Next-state logic.
  // A line is loaded from IDLE as soon as one is offered. From EMIT, a line
  // is loaded when the final chunk is consumed and another line is waiting.
  // Both paths share the same load block below, including the cnt == 0
  // drop rule.
  // -------------------------------------------------------------------------
  always_comb begin
    state_d    = state_q;
    line_buf_d = line_buf_q;
    idx_d      = idx_q;
    last_d     = last_q;
    hdr_err_d  = hdr_err_q;
    load       = 1'b0;

    case (state_q)
      S_IDLE: begin
        load = line_rdy;
      end
      S_EMIT: begin
        if (chunk_deq) begin
          if (idx_q != last_q) begin
            idx_d = idx_q + IDX_ONE;
          end else begin
            load = line_rdy;
            if (!line_rdy) begin
              state_d = S_IDLE;
            end
          end
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (load) begin
      line_buf_d = line_data;
      last_d     = eff_cnt;
      idx_d      = IDX_ONE;
      hdr_err_d  = hdr_err_q | cnt_over;
      state_d    = (eff_cnt != IDX_ZERO) ? S_EMIT : S_IDLE;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= S_IDLE;
      line_buf_q <= '0;
      idx_q      <= IDX_ONE;
      last_q     <= IDX_ZERO;
      hdr_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      line_buf_q <= line_buf_d;
      idx_q      <= idx_d;
      last_q     <= last_d;
      hdr_err_q  <= hdr_err_d;
    end
  end

  // -------------------------------------------------------------------------
  // Statistics counters.
  // -------------------------------------------------------------------------
`ifdef QA_DRV_HC_RX_SPLIT_STATS_EN
  logic [31:0] stat_lines_q, stat_lines_d;
  logic [31:0] stat_chunks_q, stat_chunks_d;

  always_comb begin
    stat_lines_d  = stat_lines_q;
    stat_chunks_d = stat_chunks_q;
    if (load) begin
      stat_lines_d = stat_lines_q + 32'd1;
    end
    // A chunk_deq counts only while a chunk is actually being offered.
    if (chunk_rdy && chunk_deq) begin
      stat_chunks_d = stat_chunks_q + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stat_lines_q  <= '0;
      stat_chunks_q <= '0;
    end else begin
      stat_lines_q  <= stat_lines_d;
      stat_chunks_q <= stat_chunks_d;
    end
  end

  assign stat_lines  = stat_lines_q;
  assign stat_chunks = stat_chunks_q;
`else
  assign stat_lines  = 32'd0;
  assign stat_chunks = 32'd0;
`endif

endmodule

// File: tb/tb_qa_drv_hc_rx_line_splitter.sv
// ---------------------------------------------------------------------------
// tb_qa_drv_hc_rx_line_splitter
//
// Directed testbench for qa_drv_hc_rx_line_splitter.
// - Inputs are driven 1 time unit after the rising edge.
// - Outputs are sampled on the falling edge.
// - The asynchronous-reset check samples 1 time unit after reset_n falls.
// ---------------------------------------------------------------------------
module tb_qa_drv_hc_rx_line_splitter;

  localparam int W = 64;

`ifdef QA_DRV_HC_RX_SPLIT_STATS_EN
  localparam logic [63:0] STATS = 64'd1;
`else
  localparam logic [63:0] STATS = 64'd0;
`endif

  // Junk in the ignored header bits, including bits just above the count
  // field, so that any misdecode of the count is exposed.
  localparam logic [63:0] HDR_JUNK = 64'hDEAD_BEEF_0000_00F0;

  logic         clk = 1'b0;
  logic         reset_n;
  logic [511:0] line_data;
  logic         line_rdy;
  logic         line_deq;
  logic [W-1:0] chunk_data;
  logic         chunk_rdy;
  logic         chunk_deq;
  logic         hdr_err;
  logic [31:0]  stat_lines;
  logic [31:0]  stat_chunks;

  int n_cmp = 0;
  int n_err = 0;

  qa_drv_hc_rx_line_splitter #(
    .N_CHUNK_BITS(64),
    .N_CNT_BITS  (4)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .line_data  (line_data),
    .line_rdy   (line_rdy),
    .line_deq   (line_deq),
    .chunk_data (chunk_data),
    .chunk_rdy  (chunk_rdy),
    .chunk_deq  (chunk_deq),
    .hdr_err    (hdr_err),
    .stat_lines (stat_lines),
    .stat_chunks(stat_chunks)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // Builds a line: header = junk | cnt, payload chunk i = base + i.
  function automatic logic [511:0] mk_line(input logic [3:0] cnt, input logic [63:0] base);
    logic [511:0] l;
    l = '0;
    l[63:0] = (HDR_JUNK & ~64'hF) | {60'd0, cnt};
    for (int i = 1; i < 8; i++) begin
      l[i*64 +: 64] = base + 64'(i);
    end
    return l;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Waits for the falling edge, then checks one offered chunk.
  task automatic exp_chunk(input string tag, input logic [63:0] data, input logic ldeq);
    @(negedge clk);
    chk({tag, "_rdy"}, {63'd0, chunk_rdy}, 64'd1);
    chk({tag, "_data"}, chunk_data, data);
    chk({tag, "_ldeq"}, {63'd0, line_deq}, {63'd0, ldeq});
    $display("chunk %s: data=%0h line_deq=%0b", tag, chunk_data, line_deq);
  endtask

  initial begin
    reset_n   = 1'b0;
    line_rdy  = 1'b0;
    chunk_deq = 1'b0;
    line_data = '0;
    step();
    step();

    // Reset state
    @(negedge clk);
    chk("rst_chunk_rdy", {63'd0, chunk_rdy}, 64'd0);
    chk("rst_line_deq", {63'd0, line_deq}, 64'd0);
    chk("rst_hdr_err", {63'd0, hdr_err}, 64'd0);
    chk("rst_chunk_data", chunk_data, 64'd0);
    chk("rst_stat_lines", {32'd0, stat_lines}, 64'd0);
    chk("rst_stat_chunks", {32'd0, stat_chunks}, 64'd0);
    step();
    reset_n = 1'b1;
    step();

    // T1: single line, cnt=3
    line_data = mk_line(4'd3, 64'hA0);
    line_rdy  = 1'b1;
    chunk_deq = 1'b1;
    @(negedge clk);
    chk("t1_line_deq", {63'd0, line_deq}, 64'd1);
    chk("t1_rdy_before", {63'd0, chunk_rdy}, 64'd0);
    step();
    line_rdy = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      exp_chunk("t1", 64'hA0 + 64'(k), 1'b0);
      step();
    end
    @(negedge clk);
    chk("t1_rdy_after", {63'd0, chunk_rdy}, 64'd0);
    step();

    // T2: back-to-back cnt=2 then cnt=7, no bubble
    line_data = mk_line(4'd2, 64'hB0);
    line_rdy  = 1'b1;
    @(negedge clk);
    chk("t2_line_deq0", {63'd0, line_deq}, 64'd1);
    step();
    line_data = mk_line(4'd7, 64'hC0);
    exp_chunk("t2_l1c1", 64'hB1, 1'b0);
    step();
    exp_chunk("t2_l1c2", 64'hB2, 1'b1);
    step();
    line_rdy = 1'b0;
    for (int k = 1; k <= 7; k++) begin
      exp_chunk("t2_l2", 64'hC0 + 64'(k), 1'b0);
      step();
    end
    @(negedge clk);
    chk("t2_rdy_after", {63'd0, chunk_rdy}, 64'd0);
    step();

    // T3: cnt=0 line dropped, then cnt=1 line
    line_data = mk_line(4'd0, 64'h30);
    line_rdy  = 1'b1;
    @(negedge clk);
    chk("t3_deq_zero", {63'd0, line_deq}, 64'd1);
    chk("t3_rdy_zero", {63'd0, chunk_rdy}, 64'd0);
    step();
    line_data = mk_line(4'd1, 64'h54);
    @(negedge clk);
    chk("t3_deq_one", {63'd0, line_deq}, 64'd1);
    chk("t3_rdy_still0", {63'd0, chunk_rdy}, 64'd0);
    step();
    line_rdy = 1'b0;
    exp_chunk("t3", 64'h55, 1'b0);
    step();
    @(negedge clk);
    chk("t3_rdy_after", {63'd0, chunk_rdy}, 64'd0);
    step();

    // T4: cnt=15 is clamped to 7 and sets hdr_err
    line_data = mk_line(4'd15, 64'hD0);
    line_rdy  = 1'b1;
    @(negedge clk);
    chk("t4_hdr_err_before", {63'd0, hdr_err}, 64'd0);
    chk("t4_line_deq", {63'd0, line_deq}, 64'd1);
    step();
    line_rdy = 1'b0;
    for (int k = 1; k <= 7; k++) begin
      exp_chunk("t4", 64'hD0 + 64'(k), 1'b0);
      chk("t4_hdr_err", {63'd0, hdr_err}, 64'd1);
      step();
    end
    @(negedge clk);
    chk("t4_rdy_after", {63'd0, chunk_rdy}, 64'd0);
    step();

    // T5: client stall on chunk 2 of a cnt=4 line; next line already waiting
    line_data = mk_line(4'd4, 64'hE0);
    line_rdy  = 1'b1;
    @(negedge clk);
    chk("t5_line_deq", {63'd0, line_deq}, 64'd1);
    step();
    line_data = mk_line(4'd1, 64'hF0);
    exp_chunk("t5_c1", 64'hE1, 1'b0);
    step();
    chunk_deq = 1'b0;
    for (int s = 0; s < 5; s++) begin
      exp_chunk("t5_stall", 64'hE2, 1'b0);
      chk("t5_hdr_err_sticky", {63'd0, hdr_err}, 64'd1);
      step();
    end
    chunk_deq = 1'b1;
    exp_chunk("t5_c2", 64'hE2, 1'b0);
    step();
    exp_chunk("t5_c3", 64'hE3, 1'b0);
    step();
    exp_chunk("t5_c4", 64'hE4, 1'b1);
    step();
    line_rdy = 1'b0;
    exp_chunk("t5_next", 64'hF1, 1'b0);
    step();
    @(negedge clk);
    chk("t5_rdy_after", {63'd0, chunk_rdy}, 64'd0);
    step();

    // T6: asynchronous reset mid-line (counters cleared beforehand)
    reset_n = 1'b0;
    step();
    reset_n = 1'b1;
    step();
    line_data = mk_line(4'd6, 64'h60);
    line_rdy  = 1'b1;
    @(negedge clk);
    chk("t6_line_deq", {63'd0, line_deq}, 64'd1);
    step();
    line_rdy = 1'b0;
    exp_chunk("t6_c1", 64'h61, 1'b0);
    step();
    exp_chunk("t6_c2", 64'h62, 1'b0);
    step();
    chk("t6_stat_lines_pre", {32'd0, stat_lines}, STATS * 64'd1);
    chk("t6_stat_chunks_pre", {32'd0, stat_chunks}, STATS * 64'd2);
    chk("t6_rdy_pre", {63'd0, chunk_rdy}, 64'd1);
    reset_n = 1'b0;
    #1;
    chk("t6_rdy_async", {63'd0, chunk_rdy}, 64'd0);
    chk("t6_stat_lines_rst", {32'd0, stat_lines}, 64'd0);
    chk("t6_stat_chunks_rst", {32'd0, stat_chunks}, 64'd0);
    chk("t6_hdr_err_rst", {63'd0, hdr_err}, 64'd0);
    step();
    reset_n = 1'b1;
    @(negedge clk);
    chk("t6_no_resume0", {63'd0, chunk_rdy}, 64'd0);
    step();
    @(negedge clk);
    chk("t6_no_resume1", {63'd0, chunk_rdy}, 64'd0);
    step();
    line_data = mk_line(4'd1, 64'h70);
    line_rdy  = 1'b1;
    @(negedge clk);
    chk("t6_next_deq", {63'd0, line_deq}, 64'd1);
    step();
    line_rdy = 1'b0;
    exp_chunk("t6_next", 64'h71, 1'b0);
    chk("t6_stat_lines_post", {32'd0, stat_lines}, STATS * 64'd1);
    step();
    @(negedge clk);
    chk("t6_rdy_after", {63'd0, chunk_rdy}, 64'd0);
    chk("t6_stat_chunks_post", {32'd0, stat_chunks}, STATS * 64'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
